// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//
// Multi-cycle integer multiply/divide unit holding the architectural HI/LO
// registers. It implements MULT, MULTU, DIV, DIVU (iterative, one bit per
// cycle) and the MTHI/MTLO register writes.
//
// Handshake: a request is taken when start=1 and busy=0 at a rising edge.
// busy stays high from the cycle after acceptance until the result is
// written. done pulses for exactly one cycle as HI/LO take the new value.
// A new start may be presented in that done cycle.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start, op, A, B operation request (op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   hi_we, lo_we    MTHI / MTLO enables, data on wdata (idle and no start only)
//   hi, lo          architectural HI / LO registers
//   busy            operation in progress
//   done            one-cycle pulse when a result lands in HI/LO
//   div_zero        one-cycle pulse with done when a divide had B=0
//   state_dbg       current FSM state (00 IDLE, 01 CALC, 10 FIX)
// ---------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state;
  logic               is_div;    // latched op[1]
  logic               neg_res;   // product / quotient must be negated
  logic               neg_rem;   // remainder must be negated (sign of A)
  logic               bz;        // divide by zero
  logic [WIDTH-1:0]   a_q;       // multiplicand, or dividend shifting into quotient
  logic [WIDTH-1:0]   b_q;       // multiplier (shifts right), or divisor
  logic [2*WIDTH-1:0] acc;       // product; low half is the remainder when dividing
  logic [CW-1:0]      cnt;

  // Operand magnitudes; op[0]=0 selects the signed variants.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  // One multiply iteration.
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] mult_next;

  // One restoring-divide iteration.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // Sign-corrected results used in FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    a_neg = A[WIDTH-1] & ~op[0];
    b_neg = B[WIDTH-1] & ~op[0];
    a_mag = a_neg ? (~A + 1'b1) : A;
    b_mag = b_neg ? (~B + 1'b1) : B;

    // LSB-first: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right with the
    // carry entering at the top.
    msum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
    mult_next = {msum, acc[WIDTH-1:1]};

    // The remainder is always below the divisor, so the W+1-bit trial
    // difference cannot overflow and its top bit is a valid sign.
    rem_sh   = {acc[WIDTH-1:0], a_q[WIDTH-1]};
    diff     = rem_sh - {1'b0, b_q};
    ge       = ~diff[WIDTH];
    rem_next = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_next = {a_q[WIDTH-2:0], ge};

    prod_fix = neg_res ? (~acc + 1'b1) : acc;
    quo_fix  = neg_res ? (~a_q + 1'b1) : a_q;
    rem_fix  = neg_rem ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      bz       <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            is_div  <= op[1];
            a_q     <= a_mag;
            b_q     <= b_mag;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg & op[1];
            bz      <= op[1] & (B == '0);
            acc     <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= S_CALC;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end

        S_CALC: begin
          if (is_div) begin
            acc[WIDTH-1:0] <= rem_next;
            a_q            <= quo_next;
          end else begin
            acc <= mult_next;
            b_q <= b_q >> 1;
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= S_FIX;
        end

        S_FIX: begin
          if (is_div) begin
            // Divide by zero: quotient forced to all ones; the corrected
            // remainder already equals A.
            lo <= bz ? '1 : quo_fix;
            hi <= rem_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done     <= 1'b1;
          div_zero <= bz;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
//
// Directed and randomized checks of muldiv_unit (WIDTH=32). Expected HI/LO
// values come from a plain-arithmetic model using 64-bit integers; they are
// queued at issue and popped when done appears.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         hi_we, lo_we;
  logic [W-1:0] wdata;
  logic [W-1:0] hi, lo;
  logic         busy, done, div_zero;
  logic [1:0]   state_dbg;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(a), .B(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [2*W:0] exp_q[$];      // {div_zero, hi, lo}
  logic [W-1:0] hi_mdl = '0;   // architectural HI/LO as the bench expects them
  logic [W-1:0] lo_mdl = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    longint     sx, sy, p, q, r;
    logic [63:0] pu;
    logic [W-1:0] h, l;
    logic dz;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    dz = 1'b0;
    h  = '0;
    l  = '0;
    case (o)
      2'd0: begin p = sx * sy; h = p[63:32]; l = p[31:0]; end
      2'd1: begin pu = {32'b0, x} * {32'b0, y}; h = pu[63:32]; l = pu[31:0]; end
      2'd2: begin
        if (y == 0) begin l = '1; h = x; dz = 1'b1; end
        else begin q = sx / sy; r = sx % sy; l = q[31:0]; h = r[31:0]; end
      end
      default: begin
        if (y == 0) begin l = '1; h = x; dz = 1'b1; end
        else begin l = x / y; h = x % y; end
      end
    endcase
    return {dz, h, l};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    exp_q.push_back(model(o, x, y));
    tick();
    start = 1'b0;
  endtask

  // Waits for done (bounded), checks latency from the accepting edge and the
  // result. Returns in the done cycle.
  task automatic wait_done(input int already, input string tag);
    int c;
    logic [2*W:0] e;
    c = already;
    while (!done && c < 200) begin
      tick();
      c++;
    end
    check({tag, " latency"}, 64'(c), 64'(W + 1));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, " hi"}, 64'(hi), 64'(e[2*W-1:W]));
    check({tag, " lo"}, 64'(lo), 64'(e[W-1:0]));
    check({tag, " div_zero"}, 64'(div_zero), 64'(e[2*W]));
    check({tag, " busy"}, 64'(busy), 64'd0);
    hi_mdl = e[2*W-1:W];
    lo_mdl = e[W-1:0];
  endtask

  task automatic pulse_end(input string tag);
    tick();
    check({tag, " done width"}, 64'(done), 64'd0);
    check({tag, " div_zero width"}, 64'(div_zero), 64'd0);
  endtask

  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input string tag);
    issue(o, x, y);
    wait_done(0, tag);
    pulse_end(tag);
  endtask

  // Directed op with literal expectations as well as the model.
  task automatic do_dir(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input string tag);
    issue(o, x, y);
    wait_done(0, tag);
    check({tag, " hi const"}, 64'(hi), 64'(eh));
    check({tag, " lo const"}, 64'(lo), 64'(el));
    pulse_end(tag);
  endtask

  task automatic mt_write(input logic wh, input logic wl, input logic [W-1:0] d);
    hi_we = wh; lo_we = wl; wdata = d;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    if (wh) hi_mdl = d;
    if (wl) lo_mdl = d;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'(W'($urandom_range(0, 20)));
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin : main
    int  seen;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset div_zero", 64'(div_zero), 64'd0);

    // Arithmetic corner cases
    do_dir(2'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult -3*5");
    do_dir(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu max");
    do_dir(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2");
    do_dir(2'd3, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, "divu");
    do_dir(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div min/-1");
    do_dir(2'd3, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, "divu by 0");
    do_dir(2'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div by 0");

    // Start while busy is ignored; start on the done cycle is accepted
    issue(2'd2, 32'd100, 32'd7);
    repeat (4) tick();
    op = 2'd1; a = 32'd2; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(5, "div 100/7");
    check("div 100/7 lo const", 64'(lo), 64'd14);
    check("div 100/7 hi const", 64'(hi), 64'd2);
    issue(2'd1, 32'd2, 32'd3);
    wait_done(0, "b2b multu");
    check("b2b multu lo const", 64'(lo), 64'd6);
    pulse_end("b2b multu");

    // MTLO / MTHI in idle
    mt_write(1'b0, 1'b1, 32'h0000_ABCD);
    check("mtlo", 64'(lo), 64'h0000_ABCD);
    mt_write(1'b1, 1'b1, 32'h0BAD_F00D);
    check("mthi+mtlo hi", 64'(hi), 64'h0BAD_F00D);
    check("mthi+mtlo lo", 64'(lo), 64'h0BAD_F00D);

    // MTHI during busy is ignored
    issue(2'd3, 32'd1000, 32'd9);
    repeat (3) tick();
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    tick();
    hi_we = 1'b0;
    check("mthi busy ignored", 64'(hi), 64'(hi_mdl));
    wait_done(4, "divu 1000/9");
    pulse_end("divu 1000/9");

    // MTHI together with start: start wins
    op = 2'd1; a = 32'd11; b = 32'd13; start = 1'b1; hi_we = 1'b1; wdata = 32'h5555_5555;
    exp_q.push_back(model(2'd1, 32'd11, 32'd13));
    tick();
    start = 1'b0; hi_we = 1'b0;
    check("mthi with start ignored", 64'(hi), 64'(hi_mdl));
    wait_done(0, "multu 11*13");
    pulse_end("multu 11*13");

    // Reset in the middle of a MULT
    mt_write(1'b1, 1'b0, 32'h0000_1234);
    check("mthi 1234", 64'(hi), 64'h0000_1234);
    issue(2'd0, 32'd12345, 32'hFFFF_FF00);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    hi_mdl = '0; lo_mdl = '0;
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    seen = 0;
    repeat (50) begin
      if (done) seen++;
      tick();
    end
    check("abort no done", 64'(seen), 64'd0);

    // Randomized operations interleaved with register writes
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom));
        check("rand mt hi", 64'(hi), 64'(hi_mdl));
        check("rand mt lo", 64'(lo), 64'(lo_mdl));
      end
      do_op(2'($urandom_range(0, 3)), pick(), pick(), "rand op");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
